game_sequencer: RTL

//   Round/shot controller for the cannon game. It sits between the control decoder and trajectory_calc.
//   - Gates player shoot requests into single-cycle fire pulses.
//   - Freezes aim while a shot is in flight.
//   - Collects result_valid/hit, keeps score and the shot budget.
//   - Requests a new target from target_gen after each hit or new game.

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_sequencer_if.sv | 38 +++
 rtl/game_sequencer_flight_timer.sv | 30 +++
 rtl/game_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the cannon-game round/shot controller.
//   SHOT_W  : width of the shots_left counter
//   DBG_W   : width of the state encoding exported on state_dbg
//   state_e : FSM state encoding (stable, exported for the debug mux)
package game_pkg;

  localparam int SHOT_W = 4;
  localparam int DBG_W  = 3;

  typedef enum logic [DBG_W-1:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    READY  = 3'd2,
    FIRE   = 3'd3,
    FLIGHT = 3'd4,
    SCORE  = 3'd5,
    OVER   = 3'd6
  } state_e;

  // Aim is frozen from the fire pulse until the shot has been scored.
  function automatic logic locks_aim(input state_e s);
    return (s == FIRE) || (s == FLIGHT) || (s == SCORE);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the game controls / trajectory_calc / target_gen side
// (master) and the game_sequencer (slave).
//   master drives : start_new_game, shoot_req, result_valid, hit, target_ready
//   slave drives  : shoot_out, new_target, lock_aim, shots_left, score,
//                   game_over, timeout_err, state_dbg
interface game_sequencer_if
  import game_pkg::*;
#(
  parameter int SCORE_W = 5
) ();

  logic               start_new_game;
  logic               shoot_req;
  logic               result_valid;
  logic               hit;
  logic               target_ready;
  logic               shoot_out;
  logic               new_target;
  logic               lock_aim;
  logic [SHOT_W-1:0]  shots_left;
  logic [SCORE_W-1:0] score;
  logic               game_over;
  logic               timeout_err;
  logic [DBG_W-1:0]   state_dbg;

  modport master (
    output start_new_game, shoot_req, result_valid, hit, target_ready,
    input  shoot_out, new_target, lock_aim, shots_left, score,
           game_over, timeout_err, state_dbg
  );

  modport slave (
    input  start_new_game, shoot_req, result_valid, hit, target_ready,
    output shoot_out, new_target, lock_aim, shots_left, score,
           game_over, timeout_err, state_dbg
  );

endinterface

// File: rtl/game_sequencer_flight_timer.sv
// Flight timer: counts FLIGHT cycles while a shot awaits its result.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : restart the count at 0 (has priority over inc_i)
//   inc_i          : advance the count by one
//   expire_o       : count has reached TIMEOUT_CYCLES-1
// The caller qualifies clr_i/inc_i with the design enable.
module flight_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q;

  assign expire_o = (count_q == LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i)                  count_q <= '0;
    else if (clr_i)               count_q <= '0;
    else if (inc_i && !expire_o)  count_q <= count_q + 1'b1;
  end

endmodule

// File: rtl/game_sequencer.sv
// Round/shot controller for the cannon game.
//   clk, reset : clock, synchronous active-high reset
//   ena        : design enable; low freezes every register (pulses included)
//   bus        : slave side of game_sequencer_if (controls, trajectory
//                result, target handshake in; fire pulse, target request,
//                aim lock, shot/score counters, status, debug state out)
// Every output is a register; next values are derived from the next state so
// pulses line up with the state that owns them.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SHOTS_PER_GAME = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SCORE_W        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  game_sequencer_if.slave   bus
);

  state_e             state_q, state_d;
  logic               start_q;
  logic               start_edge;
  logic [SHOT_W-1:0]  shots_q, shots_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_q, hit_d;
  logic               terr_q, terr_d;
  logic               shoot_q, shoot_d;
  logic               newt_q, newt_d;
  logic               lock_q, lock_d;
  logic               over_q, over_d;
  logic               tmr_expire;

  assign start_edge = bus.start_new_game & ~start_q;

  // Timer restarts as FIRE hands over to FLIGHT and only runs while the shot
  // stays in flight, so it parks on its value whenever ena is low.
  flight_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (ena && (state_q == FIRE)),
    .inc_i    (ena && (state_q == FLIGHT) && (state_d == FLIGHT)),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    shots_d = shots_q;
    score_d = score_q;
    hit_d   = hit_q;
    terr_d  = terr_q;

    if (start_edge) begin
      // A new game overrides whatever else happens this cycle, even mid-flight.
      state_d = ARM;
      shots_d = SHOT_W'(SHOTS_PER_GAME);
      score_d = '0;
      hit_d   = 1'b0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE:   ;
        ARM:    if (bus.target_ready) state_d = READY;
        READY:  if (bus.shoot_req)    state_d = FIRE;
        FIRE:   state_d = FLIGHT;
        FLIGHT: begin
          // A result arriving on the expiry cycle still counts as a result.
          if (bus.result_valid) begin
            state_d = SCORE;
            hit_d   = bus.hit;
          end else if (tmr_expire) begin
            state_d = SCORE;
            hit_d   = 1'b0;
            terr_d  = 1'b1;
          end
        end
        SCORE: begin
          if (shots_q != '0)               shots_d = shots_q - 1'b1;
          if (hit_q && (score_q != '1))    score_d = score_q + 1'b1;
          if (shots_q <= SHOT_W'(1))       state_d = OVER;
          else if (hit_q)                  state_d = ARM;
          else                             state_d = READY;
        end
        OVER:    ;
        default: state_d = IDLE;
      endcase
    end

    shoot_d = (state_d == FIRE);
    // Target request on every entry into ARM, including a restart from ARM.
    newt_d  = (state_d == ARM) && ((state_q != ARM) || start_edge);
    lock_d  = locks_aim(state_d);
    over_d  = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      shots_q <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
      terr_q  <= 1'b0;
      shoot_q <= 1'b0;
      newt_q  <= 1'b0;
      lock_q  <= 1'b0;
      over_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      start_q <= bus.start_new_game;
      shots_q <= shots_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      terr_q  <= terr_d;
      shoot_q <= shoot_d;
      newt_q  <= newt_d;
      lock_q  <= lock_d;
      over_q  <= over_d;
    end
  end

  assign bus.shoot_out   = shoot_q;
  assign bus.new_target  = newt_q;
  assign bus.lock_aim    = lock_q;
  assign bus.shots_left  = shots_q;
  assign bus.score       = score_q;
  assign bus.game_over   = over_q;
  assign bus.timeout_err = terr_q;
  assign bus.state_dbg   = state_q;

endmodule
